// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - strobe-counting timer with one-shot/periodic events on a valid/ack handshake
module tick_timer #(
  parameter int NTAPS  = 6,
  parameter int SELW   = 3,
  parameter int CWIDTH = 16,
  parameter int OWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NTAPS-1:0]  taps,
  input  logic [SELW-1:0]   sel,
  input  logic [CWIDTH-1:0] period,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  output logic              evt_valid,
  input  logic              evt_ack,
  output logic              busy,
  output logic [CWIDTH-1:0] count,
  output logic [OWIDTH-1:0] missed
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CWIDTH-1:0] C_ONE = CWIDTH'(1);
  localparam logic [OWIDTH-1:0] O_ONE = OWIDTH'(1);

  state_t              state, state_n;
  logic [SELW-1:0]     sel_l;
  logic [CWIDTH-1:0]   period_l;
  logic                mode_l;
  logic [2**SELW-1:0]  taps_pad;
  logic                sel_ok, accept, strobe, fire;

  // Selector range is wider than the tap vector; pad so any sel_l indexes safely.
  always_comb begin
    taps_pad = '0;
    taps_pad[NTAPS-1:0] = taps;
  end

  // Priority is stop > start > strobe; a strobe coinciding with stop or start is dropped.
  always_comb begin
    sel_ok  = ({{(32-SELW){1'b0}}, sel} < NTAPS);
    accept  = start && !stop && sel_ok;
    strobe  = (state == RUN) && !stop && !accept && taps_pad[sel_l];
    fire    = strobe && (count == period_l - C_ONE);
    state_n = state;
    if (stop)
      state_n = IDLE;
    else if (accept)
      state_n = RUN;
    else if (fire && !mode_l)
      state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_l     <= '0;
      period_l  <= C_ONE;
      mode_l    <= 1'b0;
      count     <= '0;
      missed    <= '0;
      evt_valid <= 1'b0;
    end else begin
      if (stop) begin
        if (state == RUN)
          count <= '0;
      end else if (accept) begin
        sel_l    <= sel;
        period_l <= (period == '0) ? C_ONE : period;
        mode_l   <= mode;
        count    <= '0;
        missed   <= '0;
      end else if (fire) begin
        count <= '0;
      end else if (strobe) begin
        count <= count + C_ONE;
      end

      // A fire in the ack cycle re-raises the event rather than counting a miss.
      if (fire) begin
        if (evt_valid && !evt_ack && (missed != '1))
          missed <= missed + O_ONE;
        evt_valid <= 1'b1;
      end else if (evt_valid && evt_ack) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// tb/tb_tick_timer.sv - table-driven self-checking bench for tick_timer
module tb_tick_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  taps = '0;
  logic [2:0]  sel = '0;
  logic [15:0] period = '0;
  logic        mode = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        evt_ack = 1'b0;
  logic        evt_valid, busy;
  logic [15:0] count;
  logic [3:0]  missed;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  tick_timer dut (
    .clk(clk), .rst_n(rst_n), .taps(taps), .sel(sel), .period(period),
    .mode(mode), .start(start), .stop(stop), .evt_valid(evt_valid),
    .evt_ack(evt_ack), .busy(busy), .count(count), .missed(missed)
  );

  typedef struct {
    string       name;
    logic [5:0]  taps;
    logic [2:0]  sel;
    logic [15:0] period;
    logic        mode, start, stop, ack;
    logic        ev, bz;
    logic [15:0] cnt;
    logic [3:0]  ms;
  } vec_t;

  vec_t vq[$];

  task automatic v(input string name, input logic [5:0] tp, input logic [2:0] s,
                   input logic [15:0] p, input logic m, input logic st, input logic sp,
                   input logic a, input logic ev, input logic bz,
                   input logic [15:0] cnt, input logic [3:0] ms);
    vec_t t;
    t.name = name; t.taps = tp; t.sel = s; t.period = p; t.mode = m;
    t.start = st; t.stop = sp; t.ack = a; t.ev = ev; t.bz = bz; t.cnt = cnt; t.ms = ms;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string name, input logic ev, input logic bz,
                           input logic [15:0] cnt, input logic [3:0] ms);
    chk({name, ".evt_valid"}, {15'd0, evt_valid}, {15'd0, ev});
    chk({name, ".busy"}, {15'd0, busy}, {15'd0, bz});
    chk({name, ".count"}, count, cnt);
    chk({name, ".missed"}, {12'd0, missed}, {12'd0, ms});
  endtask

  task automatic run(input vec_t t);
    taps = t.taps; sel = t.sel; period = t.period; mode = t.mode;
    start = t.start; stop = t.stop; evt_ack = t.ack;
    @(posedge clk);
    #1;
    check_all(t.name, t.ev, t.bz, t.cnt, t.ms);
  endtask

  initial begin
    // periodic: sel 2, period 3, acking throughout
    v("p_start", 6'h00, 2, 3, 1, 1, 0, 1, 0, 1, 0, 0);
    v("p_s1",    6'h04, 2, 3, 1, 0, 0, 1, 0, 1, 1, 0);
    v("p_s2",    6'h04, 2, 3, 1, 0, 0, 1, 0, 1, 2, 0);
    v("p_s3",    6'h04, 2, 3, 1, 0, 0, 1, 1, 1, 0, 0);
    v("p_s4",    6'h04, 2, 3, 1, 0, 0, 1, 0, 1, 1, 0);
    v("p_s5",    6'h04, 2, 3, 1, 0, 0, 1, 0, 1, 2, 0);
    v("p_s6",    6'h04, 2, 3, 1, 0, 0, 1, 1, 1, 0, 0);
    v("p_s7",    6'h04, 2, 3, 1, 0, 0, 1, 0, 1, 1, 0);
    v("p_stop",  6'h00, 2, 3, 1, 0, 1, 1, 0, 0, 0, 0);
    // one-shot: period 2
    v("os_start", 6'h00, 2, 2, 0, 1, 0, 0, 0, 1, 0, 0);
    v("os_s1",    6'h04, 2, 2, 0, 0, 0, 0, 0, 1, 1, 0);
    v("os_s2",    6'h04, 2, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    v("os_s3",    6'h04, 2, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    v("os_s4",    6'h04, 2, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    v("os_ack",   6'h00, 2, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    // missed counting and saturation: period 1, ack low
    v("ms_start", 6'h00, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++)
      v($sformatf("ms_a%0d", i), 6'h01, 0, 1, 1, 0, 0, 0, 1, 1, 0, 4'(i - 1));
    v("ms_ackfire", 6'h01, 0, 1, 1, 0, 0, 1, 1, 1, 0, 4);
    for (int j = 1; j <= 15; j++)
      v($sformatf("ms_b%0d", j), 6'h01, 0, 1, 1, 0, 0, 0, 1, 1, 0,
        (4 + j > 15) ? 4'd15 : 4'(4 + j));
    v("ms_ack",  6'h00, 0, 1, 1, 0, 0, 1, 0, 1, 0, 15);
    v("ms_stop", 6'h00, 0, 1, 1, 0, 1, 0, 0, 0, 0, 15);
    // priority / validation
    v("pr_start",     6'h00, 1, 5, 1, 1, 0, 0, 0, 1, 0, 0);
    v("pr_s1",        6'h02, 1, 5, 1, 0, 0, 0, 0, 1, 1, 0);
    v("pr_startstop", 6'h00, 1, 5, 1, 1, 1, 0, 0, 0, 0, 0);
    v("pr_badsel",    6'h3f, 6, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    v("pr_stopidle",  6'h00, 1, 5, 1, 0, 1, 0, 0, 0, 0, 0);
    // tap isolation; strobe alongside start is not counted
    v("iso_start", 6'h02, 1, 4, 1, 1, 0, 0, 0, 1, 0, 0);
    v("iso_o1",    6'h21, 1, 4, 1, 0, 0, 0, 0, 1, 0, 0);
    v("iso_o2",    6'h21, 1, 4, 1, 0, 0, 0, 0, 1, 0, 0);
    v("iso_o3",    6'h21, 1, 4, 1, 0, 0, 0, 0, 1, 0, 0);
    v("iso_s1",    6'h02, 1, 4, 1, 0, 0, 0, 0, 1, 1, 0);
    // period 0 behaves as 1
    v("p0_start", 6'h00, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    v("p0_s1",    6'h02, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    v("p0_s2",    6'h02, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0);
    v("p0_s3",    6'h02, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1);
    // re-arm keeps evt_valid, clears missed; then count to 5
    v("ar_start", 6'h00, 3, 8, 1, 1, 0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 5; i++)
      v($sformatf("ar_s%0d", i), 6'h08, 3, 8, 1, 0, 0, 0, 1, 1, 16'(i), 0);

    #1;
    check_all("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_release", 0, 0, 0, 0);

    foreach (vq[k]) run(vq[k]);

    // asynchronous reset in the middle of a cycle, away from any edge
    taps = '0; start = 1'b0; stop = 1'b0; evt_ack = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    vq.delete();
    v("rr_s1",    6'h08, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    v("rr_s2",    6'h08, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    v("rr_start", 6'h00, 3, 2, 1, 1, 0, 0, 0, 1, 0, 0);
    v("rr_a1",    6'h08, 3, 2, 1, 0, 0, 0, 0, 1, 1, 0);
    v("rr_a2",    6'h08, 3, 2, 1, 0, 0, 0, 1, 1, 0, 0);
    foreach (vq[k]) run(vq[k]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
